// File: rtl/mem_dp_be_core.sv
// Simple-dual-port memory with per-byte write strobes and a registered,
// fully pipelined read path (1..4 stages) with selectable collision behaviour.
module mem_dp_be_core #(
   parameter int unsigned ElemWidth   = 32,
   parameter int unsigned AddrWidth   = 8,
   parameter int unsigned ReadLatency = 1,
   parameter bit          WriteFirst  = 1'b1
) (
   input  logic                     clk_i,
   input  logic                     arst_ni,
   input  logic                     we_i,
   input  logic [AddrWidth-1:0]     waddr_i,
   input  logic [ElemWidth-1:0]     wdata_i,
   input  logic [ElemWidth/8-1:0]   wstrb_i,
   input  logic                     re_i,
   input  logic [AddrWidth-1:0]     raddr_i,
   output logic [ElemWidth-1:0]     rdata_o,
   output logic                     rvalid_o
);

   localparam int unsigned Depth     = 2 ** AddrWidth;
   localparam int unsigned StrbWidth = ElemWidth / 8;

   if ((ElemWidth % 8) != 0 || ElemWidth == 0) begin : g_bad_elem_width
      $error("mem_dp_be_core: ElemWidth must be a non-zero multiple of 8");
   end
   if (ReadLatency < 1 || ReadLatency > 4) begin : g_bad_read_latency
      $error("mem_dp_be_core: ReadLatency must be in 1..4");
   end

   logic [ElemWidth-1:0] r_mem [Depth];
   logic [ElemWidth-1:0] r_data [ReadLatency];
   logic [ReadLatency-1:0] r_valid;

   logic                 w_we;
   logic                 w_re;
   logic                 w_collide;
   logic [ElemWidth-1:0] w_rd_word;

   // Requests are suppressed while reset is held.
   assign w_we      = we_i & arst_ni;
   assign w_re      = re_i & arst_ni;
   assign w_collide = w_we && (waddr_i == raddr_i);

   // Read word for stage 0; write-first merges the strobed bytes of a colliding write.
   always_comb begin
      w_rd_word = r_mem[raddr_i];
      if (WriteFirst && w_collide) begin
         for (int unsigned b = 0; b < StrbWidth; b++) begin
            if (wstrb_i[b]) begin
               w_rd_word[8*b +: 8] = wdata_i[8*b +: 8];
            end
         end
      end
   end

   // Storage array is intentionally not reset.
   always_ff @(posedge clk_i) begin
      for (int unsigned b = 0; b < StrbWidth; b++) begin
         if (w_we && wstrb_i[b]) begin
            r_mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   // Read pipeline; data stages only load on valid so the output holds between pulses.
   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         r_valid <= '0;
         for (int unsigned i = 0; i < ReadLatency; i++) begin
            r_data[i] <= '0;
         end
      end else begin
         r_valid[0] <= w_re;
         if (w_re) begin
            r_data[0] <= w_rd_word;
         end
         for (int unsigned i = 1; i < ReadLatency; i++) begin
            r_valid[i] <= r_valid[i-1];
            if (r_valid[i-1]) begin
               r_data[i] <= r_data[i-1];
            end
         end
      end
   end

   assign rdata_o  = r_data[ReadLatency-1];
   assign rvalid_o = r_valid[ReadLatency-1];

endmodule

// File: tb/tb_mem_dp_be_core.sv
// Scoreboard bench for mem_dp_be_core: one write-first instance (latency 2)
// and one read-first instance (latency 3) driven by the same directed vectors.
module tb_mem_dp_be_core;

   localparam int unsigned EW    = 32;
   localparam int unsigned AW    = 8;
   localparam int unsigned LAT_A = 2;
   localparam int unsigned LAT_B = 3;

   typedef struct {
      logic [EW-1:0] data;
      int            cyc;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          we = 1'b0;
   logic [AW-1:0] waddr = '0;
   logic [EW-1:0] wdata = '0;
   logic [3:0]    wstrb = '0;
   logic          re = 1'b0;
   logic [AW-1:0] raddr = '0;
   logic [EW-1:0] rd_a, rd_b;
   logic          rv_a, rv_b;

   exp_t          q_a[$];
   exp_t          q_b[$];
   int            cyc = 0;
   int            n_tests = 0;
   int            n_fail = 0;
   logic [EW-1:0] last_a = '0;
   logic [EW-1:0] last_b = '0;

   mem_dp_be_core #(.ElemWidth(EW), .AddrWidth(AW), .ReadLatency(LAT_A), .WriteFirst(1'b1)) dut_a (
      .clk_i(clk), .arst_ni(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wstrb_i(wstrb),
      .re_i(re), .raddr_i(raddr), .rdata_o(rd_a), .rvalid_o(rv_a));

   mem_dp_be_core #(.ElemWidth(EW), .AddrWidth(AW), .ReadLatency(LAT_B), .WriteFirst(1'b0)) dut_b (
      .clk_i(clk), .arst_ni(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wstrb_i(wstrb),
      .re_i(re), .raddr_i(raddr), .rdata_o(rd_b), .rvalid_o(rv_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name, input int want_cyc);
      n_tests++;
      n_fail++;
      $display("FAIL %s: expected cycle %0d, now cycle %0d", name, want_cyc, cyc);
   endtask

   function automatic bit peek(input int id, output exp_t e);
      e = '{'0, 0};
      if (id == 0 && q_a.size() > 0) begin e = q_a[0]; return 1'b1; end
      if (id == 1 && q_b.size() > 0) begin e = q_b[0]; return 1'b1; end
      return 1'b0;
   endfunction

   function automatic void pop(input int id);
      if (id == 0) void'(q_a.pop_front());
      else         void'(q_b.pop_front());
   endfunction

   // Compares one instance's outputs against its expected-response queue.
   task automatic monitor(input int id, input logic v, input logic [EW-1:0] d);
      exp_t  e;
      bit    have;
      string nm = (id == 0) ? "A" : "B";
      logic [EW-1:0] last = (id == 0) ? last_a : last_b;
      if (!rst_n) begin
         check({nm, "_rst_rvalid"}, {31'b0, v}, '0);
         check({nm, "_rst_rdata"}, d, '0);
         if (id == 0) last_a = '0; else last_b = '0;
         return;
      end
      have = peek(id, e);
      while (have && e.cyc < cyc) begin
         flag({nm, "_missing_rvalid"}, e.cyc);
         pop(id);
         have = peek(id, e);
      end
      if (v) begin
         if (!have || e.cyc != cyc) begin
            flag({nm, "_unexpected_rvalid"}, have ? e.cyc : -1);
         end else begin
            check({nm, "_rdata"}, d, e.data);
            pop(id);
         end
         if (id == 0) last_a = d; else last_b = d;
      end else begin
         check({nm, "_hold"}, d, last);
      end
   endtask

   always @(negedge clk) begin
      monitor(0, rv_a, rd_a);
      monitor(1, rv_b, rd_b);
   end

   task automatic step(input logic w, input logic [AW-1:0] wa, input logic [EW-1:0] wd,
                       input logic [3:0] ws, input logic r, input logic [AW-1:0] ra,
                       input logic [EW-1:0] ea, input logic [EW-1:0] eb);
      @(negedge clk);
      we = w; waddr = wa; wdata = wd; wstrb = ws; re = r; raddr = ra;
      if (r && rst_n) begin
         q_a.push_back('{ea, cyc + int'(LAT_A)});
         q_b.push_back('{eb, cyc + int'(LAT_B)});
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [EW-1:0] d, input logic [3:0] s);
      step(1'b1, a, d, s, 1'b0, '0, '0, '0);
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [EW-1:0] ea, input logic [EW-1:0] eb);
      step(1'b0, '0, '0, '0, 1'b1, a, ea, eb);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
   endtask

   initial begin
      // Read requests under reset must be ignored.
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, 1'b1, 8'h10, '0, '0);
      idle(1);
      @(negedge clk); rst_n = 1'b1;

      // Full-word write then read.
      wr(8'h10, 32'hDEADBEEF, 4'hF);
      rd(8'h10, 32'hDEADBEEF, 32'hDEADBEEF);
      idle(4);

      // Partial strobes.
      wr(8'h20, 32'h11223344, 4'hF);
      wr(8'h20, 32'hAABBCCDD, 4'b0101);
      rd(8'h20, 32'h11BB33DD, 32'h11BB33DD);
      idle(4);

      // Collision, then read-after-write.
      wr(8'h05, 32'h00000000, 4'hF);
      step(1'b1, 8'h05, 32'hFFFFFFFF, 4'b0011, 1'b1, 8'h05, 32'h0000FFFF, 32'h00000000);
      rd(8'h05, 32'h0000FFFF, 32'h0000FFFF);
      // Different addresses in the same cycle do not interact.
      step(1'b1, 8'h40, 32'h55555555, 4'hF, 1'b1, 8'h10, 32'hDEADBEEF, 32'hDEADBEEF);
      rd(8'h40, 32'h55555555, 32'h55555555);
      idle(4);

      // Back-to-back reads.
      for (int i = 0; i < 4; i++) wr(AW'(i), EW'(32'hA0 + i), 4'hF);
      for (int i = 0; i < 4; i++) rd(AW'(i), EW'(32'hA0 + i), EW'(32'hA0 + i));
      idle(5);

      // Address extremes and zero-strobe write.
      wr(8'hFF, 32'hCAFEF00D, 4'hF);
      wr(8'h00, 32'h0BADF00D, 4'hF);
      rd(8'hFF, 32'hCAFEF00D, 32'hCAFEF00D);
      rd(8'h00, 32'h0BADF00D, 32'h0BADF00D);
      wr(8'hFF, 32'h00000000, 4'h0);
      rd(8'hFF, 32'hCAFEF00D, 32'hCAFEF00D);
      idle(5);

      // Reset with a read in flight: dropped, memory retained.
      rd(8'h10, 32'hDEADBEEF, 32'hDEADBEEF);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      we = 1'b0; re = 1'b0;
      q_a.delete();
      q_b.delete();
      #1;
      check("A_async_rst_rdata", rd_a, '0);
      check("A_async_rst_rvalid", {31'b0, rv_a}, '0);
      check("B_async_rst_rdata", rd_b, '0);
      check("B_async_rst_rvalid", {31'b0, rv_b}, '0);
      for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, 1'b1, 8'h10, '0, '0);
      idle(1);
      @(negedge clk); rst_n = 1'b1;
      rd(8'h10, 32'hDEADBEEF, 32'hDEADBEEF);
      rd(8'h20, 32'h11BB33DD, 32'h11BB33DD);
      idle(8);

      if (q_a.size() != 0) flag("A_drain_timeout", q_a[0].cyc);
      if (q_b.size() != 0) flag("B_drain_timeout", q_b[0].cyc);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
